// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the framebuffer RAM arbiter.
package fb_arb_pkg;

    // Which agent owns the RAM port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_ACC  = 2'd2,
        GNT_CPU  = 2'd3
    } grant_t;

    // 640x480 at 1 bpp, 32 pixels per word.
    localparam int FRAME_WORDS_DEFAULT = 9600;
    // Below this many words (queued plus in flight) display fetches jump ahead of requesters.
    localparam int LOW_WATER_DEFAULT   = 4;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Display prefetch FIFO: first-word-fall-through head, synchronous flush.
// A push and a pop in the same cycle leave the count unchanged. If the FIFO is
// empty, the pushed word is consumed by that pop.
module fb_prefetch_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array is written only; it needs no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter and scanout prefetcher. Each cycle the single RAM port
// goes to an urgent display fetch, then to the accelerator or CPU (round-robin
// on ties), then to an opportunistic display fetch.
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int LOW_WATER   = LOW_WATER_DEFAULT,
    parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              underflow_clr,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [DATA_W-1:0] acc_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FA_W  = ADDR_W + 1;

    grant_t            grant;
    grant_t            rr_last;
    logic [FA_W-1:0]   fetch_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              disp_pend;
    logic              disp_drop;
    logic              disp_live;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occ;
    logic              fetch_more;
    logic              uf_event;

    // A display read whose frame was flushed still occupies the RAM pipe but will never land.
    assign disp_live  = disp_pend && !disp_drop;
    assign occ        = fifo_count + CNT_W'(disp_live);
    assign fetch_more = (fetch_addr < FA_W'(FRAME_WORDS));
    assign fifo_push  = disp_live && !frame_start;
    assign fifo_pop   = pix_rd && !frame_start;
    assign uf_event   = pix_rd && !pix_valid && !frame_start;
    assign pix_valid  = (fifo_count != '0);

    fb_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .head      (pix_data),
        .count     (fifo_count)
    );

    // Priority pick of the single RAM owner; reset forces no grant so outputs settle immediately.
    always_comb begin
        grant = GNT_NONE;
        if (reset) begin
            grant = GNT_NONE;
        end else if (occ < CNT_W'(LOW_WATER) && fetch_more) begin
            grant = GNT_DISP;
        end else if (acc_req && cpu_req) begin
            grant = (rr_last == GNT_CPU) ? GNT_ACC : GNT_CPU;
        end else if (acc_req) begin
            grant = GNT_ACC;
        end else if (cpu_req) begin
            grant = GNT_CPU;
        end else if (occ < CNT_W'(FIFO_DEPTH) && fetch_more) begin
            grant = GNT_DISP;
        end
    end

    // Drive the RAM port from the granted agent; an idle cycle parks the address.
    always_comb begin
        mem_addr  = last_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (grant)
            GNT_DISP: mem_addr = fetch_addr[ADDR_W-1:0];
            GNT_ACC: begin
                mem_addr  = acc_addr;
                mem_we    = acc_we;
                mem_wdata = acc_wdata;
            end
            GNT_CPU: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    assign acc_gnt   = (grant == GNT_ACC);
    assign cpu_gnt   = (grant == GNT_CPU);
    assign acc_rdata = acc_rvalid ? mem_rdata : '0;
    assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;

    // Fetch pointer, round-robin history and in-flight read tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr <= '0;
            rr_last    <= GNT_CPU;
            last_addr  <= '0;
            disp_pend  <= 1'b0;
            disp_drop  <= 1'b0;
            acc_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            if (frame_start) begin
                fetch_addr <= '0;
            end else if (grant == GNT_DISP) begin
                fetch_addr <= fetch_addr + 1'b1;
            end
            if (grant == GNT_ACC || grant == GNT_CPU) begin
                rr_last <= grant;
            end
            last_addr  <= mem_addr;
            disp_pend  <= (grant == GNT_DISP);
            disp_drop  <= (grant == GNT_DISP) && frame_start;
            acc_rvalid <= (grant == GNT_ACC) && !acc_we;
            cpu_rvalid <= (grant == GNT_CPU) && !cpu_we;
        end
    end

    // Sticky underflow; a new underflow in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (uf_event) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: RAM behavioural model plus a queue-based reference of the arbiter.
module tb_fb_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int LW = 4;
    localparam int FW = 9600;
    localparam int G_NONE = 0;
    localparam int G_DISP = 1;
    localparam int G_ACC  = 2;
    localparam int G_CPU  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_rd = 1'b0;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          underflow;
    logic          underflow_clr = 1'b0;
    logic          acc_req = 1'b0, acc_we = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0;
    logic          acc_gnt, acc_rvalid;
    logic [DW-1:0] acc_rdata;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #10 clk = ~clk;

    fb_mem_arbiter dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .underflow_clr(underflow_clr),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hC0DE_0000 ^ DW'(a);
    endfunction

    // Bench RAM: synchronous, read data one cycle after the address.
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    bit            ram_vld [0:(1<<AW)-1];
    always @(posedge clk) begin
        mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            ram_vld[mem_addr] <= 1'b1;
        end
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] q [$];
    int            m_fetch;
    bit            m_pend, m_drop, m_rr_cpu, m_uf, m_acc_rv, m_cpu_rv;
    logic [DW-1:0] m_pend_data, m_acc_rd, m_cpu_rd;
    logic [AW-1:0] m_last;
    int            g;

    logic          obs_acc, obs_cpu, obs_pv, obs_uf, obs_cpu_rv;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_cpu_rd;

    task automatic model_reset();
        q.delete();
        m_fetch = 0;
        m_pend = 0; m_drop = 0; m_rr_cpu = 1; m_uf = 0;
        m_acc_rv = 0; m_cpu_rv = 0;
        m_pend_data = '0; m_acc_rd = '0; m_cpu_rd = '0;
        m_last = '0;
    endtask

    function automatic int model_grant();
        int  occ;
        bit  more;
        occ  = q.size() + ((m_pend && !m_drop) ? 1 : 0);
        more = (m_fetch < FW);
        if (occ < LW && more) return G_DISP;
        if (acc_req && cpu_req) return m_rr_cpu ? G_ACC : G_CPU;
        if (acc_req) return G_ACC;
        if (cpu_req) return G_CPU;
        if (occ < DEPTH && more) return G_DISP;
        return G_NONE;
    endfunction

    task automatic model_update(input logic [AW-1:0] ea);
        int sz;
        bit push, pop;
        sz   = q.size();
        push = m_pend && !m_drop && !frame_start;
        pop  = pix_rd && !frame_start;
        if (pix_rd && !frame_start && sz == 0) m_uf = 1;
        else if (underflow_clr) m_uf = 0;
        if (frame_start) q.delete();
        else if (push && pop) begin
            if (sz != 0) begin
                void'(q.pop_front());
                q.push_back(m_pend_data);
            end
        end else if (push) q.push_back(m_pend_data);
        else if (pop && sz != 0) void'(q.pop_front());
        m_pend = (g == G_DISP);
        m_drop = (g == G_DISP) && frame_start;
        if (g == G_DISP) m_pend_data = sram[m_fetch];
        m_acc_rv = (g == G_ACC) && !acc_we;
        m_cpu_rv = (g == G_CPU) && !cpu_we;
        if (m_acc_rv) m_acc_rd = sram[acc_addr];
        if (m_cpu_rv) m_cpu_rd = sram[cpu_addr];
        if (g == G_ACC && acc_we) sram[acc_addr] = acc_wdata;
        if (g == G_CPU && cpu_we) sram[cpu_addr] = cpu_wdata;
        if (g == G_ACC) m_rr_cpu = 0;
        if (g == G_CPU) m_rr_cpu = 1;
        m_last = ea;
        if (frame_start) m_fetch = 0;
        else if (g == G_DISP) m_fetch = m_fetch + 1;
    endtask

    // One clock: predict, compare at the falling edge, advance the model after the rising edge.
    task automatic cycle();
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        g   = model_grant();
        ea  = m_last; ewe = 1'b0; ewd = '0;
        case (g)
            G_DISP: ea = AW'(m_fetch);
            G_ACC:  begin ea = acc_addr; ewe = acc_we; ewd = acc_wdata; end
            G_CPU:  begin ea = cpu_addr; ewe = cpu_we; ewd = cpu_wdata; end
            default: ;
        endcase
        @(negedge clk);
        chk("acc_gnt", acc_gnt, g == G_ACC);
        chk("cpu_gnt", cpu_gnt, g == G_CPU);
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", mem_we, ewe);
        if (ewe) chk("mem_wdata", mem_wdata, ewd);
        chk("pix_valid", pix_valid, q.size() != 0);
        if (q.size() != 0) chk("pix_data", pix_data, q[0]);
        chk("underflow", underflow, m_uf);
        chk("acc_rvalid", acc_rvalid, m_acc_rv);
        chk("cpu_rvalid", cpu_rvalid, m_cpu_rv);
        if (m_acc_rv) chk("acc_rdata", acc_rdata, m_acc_rd);
        if (m_cpu_rv) chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        obs_acc = acc_gnt; obs_cpu = cpu_gnt; obs_pv = pix_valid; obs_uf = underflow;
        obs_addr = mem_addr; obs_cpu_rv = cpu_rvalid; obs_cpu_rd = cpu_rdata;
        @(posedge clk);
        #1;
        model_update(ea);
    endtask

    task automatic reset_check(input string pfx);
        chk({pfx, "_pix_valid"}, pix_valid, 0);
        chk({pfx, "_underflow"}, underflow, 0);
        chk({pfx, "_acc_gnt"}, acc_gnt, 0);
        chk({pfx, "_cpu_gnt"}, cpu_gnt, 0);
        chk({pfx, "_acc_rvalid"}, acc_rvalid, 0);
        chk({pfx, "_cpu_rvalid"}, cpu_rvalid, 0);
        chk({pfx, "_mem_we"}, mem_we, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_pix_data"}, pix_data, 0);
        chk({pfx, "_acc_rdata"}, acc_rdata, 0);
        chk({pfx, "_cpu_rdata"}, cpu_rdata, 0);
    endtask

    task automatic new_acc();
        acc_we    = 1'($urandom_range(0, 1));
        acc_addr  = AW'($urandom_range(0, 63));
        acc_wdata = $urandom;
    endtask

    task automatic new_cpu();
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, 63));
        cpu_wdata = $urandom;
    endtask

    // Keep requests held until granted; after a grant, maybe issue a fresh one.
    task automatic refresh_reqs(input bit keep);
        if (g == G_ACC) begin
            acc_req = keep ? 1'b1 : 1'($urandom_range(0, 1));
            new_acc();
        end else if (!acc_req && $urandom_range(0, 3) == 0) begin
            acc_req = 1'b1;
            new_acc();
        end
        if (g == G_CPU) begin
            cpu_req = keep ? 1'b1 : 1'($urandom_range(0, 1));
            new_cpu();
        end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
            cpu_req = 1'b1;
            new_cpu();
        end
    endtask

    initial begin
        int first_pv;
        int budget;
        for (int i = 0; i < (1 << AW); i++) sram[i] = init_word(i);
        model_reset();

        // Reset held with requests active: outputs stay at reset values.
        acc_req = 1; acc_we = 1; acc_wdata = 32'h1234_5678; acc_addr = 14'h55;
        cpu_req = 1; cpu_we = 1; cpu_wdata = 32'h8765_4321; cpu_addr = 14'h66;
        #25;
        reset_check("rst");
        acc_req = 0; acc_we = 0; acc_wdata = '0; acc_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_wdata = '0; cpu_addr = '0;
        @(posedge clk);
        #1;
        reset = 0;

        // Fill after reset with no requests.
        first_pv = -1;
        for (int c = 0; c < 17; c++) begin
            cycle();
            if (obs_pv && first_pv < 0) first_pv = c;
        end
        chk("pv_rise_cycle", first_pv, 2);
        chk("fill_fetch_addr", dut.fetch_addr, 16);
        cycle();
        chk("fill_idle_addr", obs_addr, 15);

        // Both requesters held with FIFO full: alternate, write then read back.
        acc_req = 1; acc_we = 1; acc_addr = 14'h10; acc_wdata = 32'hDEADBEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h10;
        cycle();
        chk("rr_first_acc", obs_acc, 1);
        acc_we = 0; acc_addr = 14'h20;
        cycle();
        chk("rr_second_cpu", obs_cpu, 1);
        cpu_addr = 14'h30;
        cycle();
        chk("rr_third_acc", obs_acc, 1);
        chk("raw_rvalid", obs_cpu_rv, 1);
        chk("raw_rdata", obs_cpu_rd, 32'hDEADBEEF);
        acc_addr = 14'h21;
        cycle();
        chk("rr_fourth_cpu", obs_cpu, 1);

        // Drain to the low-water mark with both requesters busy, then let it recover.
        for (int c = 0; c < 24; c++) begin
            pix_rd = (c < 16);
            refresh_reqs(1);
            cycle();
        end
        pix_rd = 0; acc_req = 0; cpu_req = 0;

        // frame_start the cycle after a display grant.
        budget = 0;
        while (q.size() + (m_pend ? 1 : 0) < DEPTH && budget < 40) begin
            cycle();
            budget++;
        end
        chk("refill_budget", budget < 40, 1);
        pix_rd = 1;
        cycle();
        pix_rd = 0;
        cycle();
        chk("pre_fs_disp_addr", obs_addr, AW'(m_fetch - 1));
        frame_start = 1;
        cycle();
        frame_start = 0;
        cycle();
        chk("fs_pix_valid", obs_pv, 0);
        chk("fs_fetch_addr0", obs_addr, 0);
        cycle();
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            refresh_reqs(0);
            pix_rd        = ($urandom_range(0, 99) < 45);
            frame_start   = ($urandom_range(0, 249) == 0);
            underflow_clr = ($urandom_range(0, 19) == 0);
            cycle();
        end
        acc_req = 0; cpu_req = 0; pix_rd = 0; frame_start = 0; underflow_clr = 0;
        cycle();

        // Full frame drained by the display.
        underflow_clr = 1;
        frame_start = 1;
        cycle();
        frame_start = 0;
        underflow_clr = 0;
        budget = 0;
        while ((m_fetch < FW || q.size() != 0 || m_pend) && budget < 12000) begin
            pix_rd = (q.size() != 0);
            cycle();
            budget++;
        end
        pix_rd = 0;
        chk("frame_budget", budget < 12000, 1);
        chk("frame_fetch_end", dut.fetch_addr, FW);
        cycle();
        chk("frame_end_uf_clear", obs_uf, 0);
        pix_rd = 1;
        cycle();
        pix_rd = 0;
        cycle();
        chk("extra_pop_uf", obs_uf, 1);
        underflow_clr = 1;
        cycle();
        underflow_clr = 0;
        cycle();
        chk("uf_cleared", obs_uf, 0);
        pix_rd = 1; underflow_clr = 1;
        cycle();
        pix_rd = 0; underflow_clr = 0;
        cycle();
        chk("uf_set_wins", obs_uf, 1);

        // Reset while a cpu read is outstanding.
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h10;
        cycle();
        chk("pre_rst_cpu_gnt", obs_cpu, 1);
        reset = 1;
        #1;
        reset_check("midrst");
        cpu_req = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        for (int c = 0; c < 6; c++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
